mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_arb_pkg.sv | 21 ++
 rtl/mem_arb_inflight.sv | 42 ++++
 rtl/mem_port_arbiter.sv | 95 +++++++++
 tb/tb_mem_port_arbiter.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and default constants for the single-port memory arbiter.
// Tags mark what each in-flight memory access belongs to.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        TAG_NONE = 2'd0,
        TAG_IF   = 2'd1,
        TAG_DM   = 2'd2
    } tag_t;

    localparam int DEF_ADDR_W     = 10;
    localparam int DEF_MEM_LAT    = 2;
    localparam int DEF_STARVE_MAX = 4;
    localparam int DATA_W         = 32;

    // A redirect kills fetches only; data accesses must still complete.
    function automatic tag_t squash_tag(input tag_t t, input logic squash);
        return (squash && t == TAG_IF) ? TAG_NONE : t;
    endfunction

endpackage

// File: rtl/mem_arb_inflight.sv
// Tag delay line: one slot per memory latency cycle, oldest slot drives rvalid.
// A squash rewrites every fetch tag in flight (and any entering) to NONE.
module mem_arb_inflight
    import mem_arb_pkg::*;
#(
    parameter int DEPTH = DEF_MEM_LAT
) (
    input  logic clk,
    input  logic rst_n,
    input  tag_t tag_in,
    input  logic squash,
    output tag_t tag_out,
    output logic busy
);

    tag_t pipe [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                pipe[i] <= TAG_NONE;
            end
        end else begin
            pipe[0] <= squash_tag(tag_in, squash);
            for (int i = 1; i < DEPTH; i++) begin
                pipe[i] <= squash_tag(pipe[i-1], squash);
            end
        end
    end

    always_comb begin
        busy = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (pipe[i] != TAG_NONE) begin
                busy = 1'b1;
            end
        end
    end

    assign tag_out = pipe[DEPTH-1];

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates fetch and MEM-stage accesses onto one pipelined memory port,
// with data priority, fetch anti-starvation and flush squashing of fetches.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int MEM_LAT    = DEF_MEM_LAT,
    parameter int STARVE_MAX = DEF_STARVE_MAX,
    localparam int CNT_W     = $clog2(STARVE_MAX + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic              dm_gnt,
    output logic              dm_rvalid,
    input  logic              flush,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [CNT_W-1:0]  starve_cnt,
    output logic              inflight_busy
);

    if (MEM_LAT < 1 || MEM_LAT > 4) begin : g_bad_lat
        $error("mem_port_arbiter: MEM_LAT must be 1..4");
    end

    // Handshake: a requester holds req (and its address/data) until it sees
    // gnt in the same cycle; gnt is the transfer, there is no back-pressure
    // on the response side, so rvalid is a one-cycle pulse MEM_LAT later.
    logic starve_hit;
    logic if_win;
    tag_t tag_in;
    tag_t tag_out;

    assign starve_hit = (starve_cnt == CNT_W'(STARVE_MAX));

    always_comb begin
        if_win = rst_n && if_req && !flush && (!dm_req || starve_hit);
        if_gnt = if_win;
        dm_gnt = rst_n && dm_req && !if_win;
    end

    always_comb begin
        mem_en    = if_gnt | dm_gnt;
        mem_we    = dm_gnt & dm_we;
        mem_addr  = '0;
        mem_wdata = '0;
        tag_in    = TAG_NONE;
        if (dm_gnt) begin
            mem_addr  = dm_addr;
            mem_wdata = dm_wdata;
            tag_in    = TAG_DM;
        end else if (if_gnt) begin
            mem_addr  = if_addr;
            tag_in    = TAG_IF;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt <= '0;
        end else if (!if_req || if_gnt || flush) begin
            starve_cnt <= '0;
        end else if (!starve_hit) begin
            starve_cnt <= starve_cnt + CNT_W'(1);
        end
    end

    mem_arb_inflight #(
        .DEPTH (MEM_LAT)
    ) u_inflight (
        .clk     (clk),
        .rst_n   (rst_n),
        .tag_in  (tag_in),
        .squash  (flush),
        .tag_out (tag_out),
        .busy    (inflight_busy)
    );

    // A fetch emerging during a flush is already dead, so it is masked here too.
    always_comb begin
        if_rvalid = rst_n && (tag_out == TAG_IF) && !flush;
        dm_rvalid = rst_n && (tag_out == TAG_DM);
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter at MEM_LAT=2, STARVE_MAX=4.
// Inputs change 1ns after the rising edge; outputs are sampled on the falling edge.
module tb_mem_port_arbiter;

    logic        clk;
    logic        rst_n;
    logic        if_req;
    logic [9:0]  if_addr;
    logic        if_gnt;
    logic        if_rvalid;
    logic        dm_req;
    logic        dm_we;
    logic [9:0]  dm_addr;
    logic [31:0] dm_wdata;
    logic        dm_gnt;
    logic        dm_rvalid;
    logic        flush;
    logic        mem_en;
    logic        mem_we;
    logic [9:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [2:0]  starve_cnt;
    logic        inflight_busy;

    int total = 0;
    int bad   = 0;

    // expected {if_rvalid, dm_rvalid} per cycle of the current test
    logic [1:0] exp_q[$];

    mem_port_arbiter #(
        .ADDR_W     (10),
        .MEM_LAT    (2),
        .STARVE_MAX (4)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .if_req        (if_req),
        .if_addr       (if_addr),
        .if_gnt        (if_gnt),
        .if_rvalid     (if_rvalid),
        .dm_req        (dm_req),
        .dm_we         (dm_we),
        .dm_addr       (dm_addr),
        .dm_wdata      (dm_wdata),
        .dm_gnt        (dm_gnt),
        .dm_rvalid     (dm_rvalid),
        .flush         (flush),
        .mem_en        (mem_en),
        .mem_we        (mem_we),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .starve_cnt    (starve_cnt),
        .inflight_busy (inflight_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One cycle: drive inputs after the edge, then check grants and rvalids.
    task automatic cyc(input string tag, input logic rst,
                       input logic i_req, input logic [9:0] i_addr,
                       input logic d_req, input logic d_we, input logic [9:0] d_addr,
                       input logic [31:0] d_wdata, input logic fl,
                       input logic exp_ig, input logic exp_dg);
        logic [1:0] exp_rv;
        @(posedge clk);
        #1;
        rst_n    = rst;
        if_req   = i_req;
        if_addr  = i_addr;
        dm_req   = d_req;
        dm_we    = d_we;
        dm_addr  = d_addr;
        dm_wdata = d_wdata;
        flush    = fl;
        @(negedge clk);
        exp_rv = (exp_q.size() > 0) ? exp_q.pop_front() : 2'b00;
        check({tag, ".if_gnt"},    32'(if_gnt),    32'(exp_ig));
        check({tag, ".dm_gnt"},    32'(dm_gnt),    32'(exp_dg));
        check({tag, ".mem_en"},    32'(mem_en),    32'(exp_ig | exp_dg));
        check({tag, ".mem_we"},    32'(mem_we),    32'(exp_dg & d_we));
        check({tag, ".if_rvalid"}, 32'(if_rvalid), 32'(exp_rv[1]));
        check({tag, ".dm_rvalid"}, 32'(dm_rvalid), 32'(exp_rv[0]));
    endtask

    task automatic idle(input string tag);
        cyc(tag, 1'b1, 1'b0, 10'd0, 1'b0, 1'b0, 10'd0, 32'd0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        rst_n    = 1'b0;
        if_req   = 1'b1;
        if_addr  = 10'd5;
        dm_req   = 1'b1;
        dm_we    = 1'b0;
        dm_addr  = 10'd6;
        dm_wdata = 32'd0;
        flush    = 1'b0;

        // reset holds everything off even with requests present
        @(negedge clk);
        @(negedge clk);
        check("rst.if_gnt",     32'(if_gnt),     32'd0);
        check("rst.dm_gnt",     32'(dm_gnt),     32'd0);
        check("rst.mem_en",     32'(mem_en),     32'd0);
        check("rst.rvalid",     32'({if_rvalid, dm_rvalid}), 32'd0);
        check("rst.starve_cnt", 32'(starve_cnt), 32'd0);
        rst_n  = 1'b1;
        if_req = 1'b0;
        dm_req = 1'b0;

        // fetch alone at address 5
        exp_q = '{2'b00, 2'b00, 2'b10, 2'b00};
        cyc("a0", 1'b1, 1'b1, 10'd5, 1'b0, 1'b0, 10'd0, 32'd0, 1'b0, 1'b1, 1'b0);
        check("a0.mem_addr", 32'(mem_addr), 32'd5);
        idle("a1");
        idle("a2");
        idle("a3");

        // data read beats fetch, fetch follows next cycle
        exp_q = '{2'b00, 2'b00, 2'b01, 2'b10, 2'b00};
        cyc("b0", 1'b1, 1'b1, 10'd7, 1'b1, 1'b0, 10'd1022, 32'd0, 1'b0, 1'b0, 1'b1);
        check("b0.mem_addr", 32'(mem_addr), 32'd1022);
        cyc("b1", 1'b1, 1'b1, 10'd7, 1'b0, 1'b0, 10'd0, 32'd0, 1'b0, 1'b1, 1'b0);
        check("b1.mem_addr", 32'(mem_addr), 32'd7);
        check("b1.starve_cnt", 32'(starve_cnt), 32'd1);
        idle("b2");
        idle("b3");
        idle("b4");

        // continuous contention: fetch forced through after four denials
        exp_q = '{2'b00, 2'b00, 2'b01, 2'b01, 2'b01, 2'b01, 2'b10, 2'b01, 2'b00};
        for (int i = 0; i < 6; i++) begin
            cyc($sformatf("c%0d", i), 1'b1, 1'b1, 10'd100, 1'b1, 1'b0, 10'(200 + i), 32'd0,
                1'b0, (i == 4), (i != 4));
            if (i == 4) check("c4.starve_cnt", 32'(starve_cnt), 32'd4);
            if (i == 5) check("c5.starve_cnt", 32'(starve_cnt), 32'd0);
        end
        idle("c6");
        idle("c7");
        idle("c8");

        // flush squashes the fetch in flight but not the data read
        exp_q = '{2'b00, 2'b00, 2'b00, 2'b01, 2'b00};
        cyc("d0", 1'b1, 1'b1, 10'd3, 1'b0, 1'b0, 10'd0, 32'd0, 1'b0, 1'b1, 1'b0);
        cyc("d1", 1'b1, 1'b1, 10'd3, 1'b1, 1'b0, 10'd9, 32'd0, 1'b1, 1'b0, 1'b1);
        idle("d2");
        check("d2.starve_cnt", 32'(starve_cnt), 32'd0);
        idle("d3");
        idle("d4");

        // data write is acknowledged like a read
        exp_q = '{2'b00, 2'b00, 2'b01, 2'b00};
        cyc("e0", 1'b1, 1'b0, 10'd0, 1'b1, 1'b1, 10'd1021, 32'h0000_00A5, 1'b0, 1'b0, 1'b1);
        check("e0.mem_addr",  32'(mem_addr), 32'd1021);
        check("e0.mem_wdata", mem_wdata,     32'h0000_00A5);
        idle("e1");
        idle("e2");
        idle("e3");

        // reset with two accesses in flight discards both
        exp_q = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
        cyc("f0", 1'b1, 1'b1, 10'd2, 1'b0, 1'b0, 10'd0, 32'd0, 1'b0, 1'b1, 1'b0);
        cyc("f1", 1'b1, 1'b0, 10'd0, 1'b1, 1'b0, 10'd4, 32'd0, 1'b0, 1'b0, 1'b1);
        cyc("f2", 1'b0, 1'b1, 10'd2, 1'b1, 1'b0, 10'd4, 32'd0, 1'b0, 1'b0, 1'b0);
        check("f2.starve_cnt", 32'(starve_cnt), 32'd0);
        check("f2.busy",       32'(inflight_busy), 32'd0);
        idle("f3");
        idle("f4");
        idle("f5");

        check("q_drained", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
